xmem_seq: RTL and testbench
===========================

# xmem_seq

Parametrised external-memory access sequencer for the MISA-O core. It executes XMEM loads and stores of nibble, byte, 16-bit or full-width data over the 8-bit memory bus, one byte per cycle, in little-endian order. It holds a bank of address registers with post-increment, post-decrement and optional pre-decrement. It sits between the core's execute stage and the memory port, replacing the fixed two-register, 16-bit XMEM path.

## Interface
- `ADDR_W`, 15: memory address width; address arithmetic is modulo 2^ADDR_W.
- `DATA_W`, 16: maximum access width; must be a multiple of 8 and at least 16.
- `N_AR`, 2: number of address registers; must be at least 2.
- `AR_SEL_W` is derived as max(1, clog2(N_AR)).

Ports:
- `clk`  in  1  the single clock.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  access request.
- `req_ready`  out  1  high only in IDLE.
- `req_store`  in  1  1 = store, 0 = load.
- `req_mode`  in  2  access size: 00 nibble (1 byte on bus), 01 byte, 10 16-bit, 11 DATA_W.
- `req_ar`  in  AR_SEL_W  address register used for the access.
- `req_post`  in  2  address update: 00 none, 01 post-inc, 10 post-dec, 11 pre-dec (see Configuration).
- `req_wdata`  in  DATA_W  store data.
- `ar_wr_en`  in  1  direct address-register write.
- `ar_wr_sel`  in  AR_SEL_W  register selected for the direct write.
- `ar_wr_data`  in  ADDR_W  value for the direct write.
- `ar_rd_sel`  in  AR_SEL_W  register selected for readback.
- `ar_rd_data`  out  ADDR_W  combinational readback of the selected register.
- `mem_enable_read`  out  1  memory read strobe.
- `mem_enable_write`  out  1  memory write strobe.
- `mem_addr`  out  ADDR_W  memory byte address.
- `mem_data_out`  out  8  store byte.
- `mem_data_in`  in  8  load byte; combinational, valid in the same cycle as `mem_enable_read`.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_rdata`  out  DATA_W  load result, held until the next load completes.

## Operation
- Byte count N: 1 for nibble and byte modes, 2 for 16-bit, DATA_W/8 for full width.
- State machine:
  - IDLE: when req_valid and req_ready, latch the request and the base address, then go to XFER.
  - XFER: one byte per cycle; after byte N-1, go to RESP.
  - RESP: assert rsp_valid for one cycle, then go to IDLE.
- Base address:
  - Pre-dec: AR - N.
  - Otherwise: AR.
- Byte k is transferred at address base+k, with wrap.
- Store data:
  - Byte k = req_wdata[8k+7:8k], so bytes go out low byte first.
  - Nibble mode writes {4'h0, wdata[3:0]}.
- Load data:
  - Byte k is assembled into rsp_rdata[8k+7:8k]; upper bits are zero.
  - Nibble mode returns {0, mem_data_in[3:0]}.
- Address register update is written at the edge that ends the last XFER cycle:
  - Post-inc: base+N.
  - Post-dec: base-N.
  - Pre-dec: base.
  - None: unchanged.
- Collisions: a direct write (ar_wr_en) has priority over the update of the same register. Writes to different registers both take effect.
- Requests arriving while req_ready is low are ignored; the requester holds req_valid until it is accepted.

## Timing
- Request accepted at edge 0. The byte-k strobe is high in cycle 1+k. rsp_valid is high in cycle N+1. req_ready rises in cycle N+2.
- Accepted-request-to-rsp_valid latency is N+1 cycles. Back-to-back throughput is one access per N+2 cycles.
- Memory samples the write on the rising edge that ends a strobe cycle. Loads capture mem_data_in on that same edge.
- Exactly one of mem_enable_read and mem_enable_write is high per XFER cycle; both are low in IDLE and RESP.
- Reset values: state IDLE, all AR 0, rsp_rdata 0, and all outputs 0 except req_ready=1. mem_addr is 0.
- Reset asserted mid-access aborts it immediately, with no further strobes. Bytes already written stay in memory and no AR update occurs.
- Address wrap examples with ADDR_W=15: 0x7FFF+1 = 0x0000 and 0x0000-2 = 0x7FFE.

## Configuration
- `XMEM_PREDEC_EN`:
  - Defined: req_post=11 performs pre-decrement as described above, enabling a push/pop stack through any AR.
  - Undefined: req_post=11 behaves exactly as 00 (no update), and the pre-dec subtractor is not built.

## Test plan
- UL mode:
  - Stimulus: AR0=0x0080. Store nibble 0x5 with post-inc, then store nibble 0x3 with no update, then load nibble.
  - Response: [0x80]=05, [0x81]=03, AR0=0x0081, rsp_rdata=0x0003.
- LK8 mode:
  - Stimulus: AR0=0x0081. Store 0x5B with post-inc, then store 0x00. Load with post-inc, then load with post-dec.
  - Response: [0x81]=5B, [0x82]=00, both loads return 0x0000, final AR0=0x0082.
- LK16 mode on AR1:
  - Stimulus: AR1=0x0090. Store 0x1234 with post-inc, then load with post-dec.
  - Response: [0x90]=34, [0x91]=12, rsp_rdata=0x1234 read from 0x0092? No: the load is at 0x0092 and returns 0x0000, with AR1 ending at 0x0090. A second load with no update then returns 0x1234.
- Full width with DATA_W=32, address wrap and pre-dec:
  - Stimulus: AR1=0x7FFE. Store 0xCAFEBABE with post-inc.
  - Response: bytes BE, BA, FE, CA land at 0x7FFE, 0x7FFF, 0x0000, 0x0001, and AR1=0x0002.
  - With XMEM_PREDEC_EN defined, a pre-dec load returns 0xCAFEBABE and AR1=0x7FFE.
- Collision, stalled request and reset:
  - Stimulus: ar_wr_en to AR0=0x0100 in the same cycle as AR0's post-inc update. Separately, raise req_valid during XFER. Separately, assert rst during byte 1 of a 16-bit store.
  - Response: AR0=0x0100. The request raised during XFER is not accepted until req_ready returns. After the reset, only byte 0 is written, all AR are 0, and req_ready=1.

Source files
------------

// File: rtl/xmem_seq_if.sv
// Request, address-register and memory-bus signals of the XMEM access sequencer.
// master = core/memory side, slave = sequencer.
interface xmem_seq_if #(
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned N_AR   = 2
);
    localparam int unsigned AR_SEL_W = ($clog2(N_AR) > 1) ? $clog2(N_AR) : 1;

    logic                req_valid;
    logic                req_ready;
    logic                req_store;
    logic [1:0]          req_mode;
    logic [AR_SEL_W-1:0] req_ar;
    logic [1:0]          req_post;
    logic [DATA_W-1:0]   req_wdata;

    logic                ar_wr_en;
    logic [AR_SEL_W-1:0] ar_wr_sel;
    logic [ADDR_W-1:0]   ar_wr_data;
    logic [AR_SEL_W-1:0] ar_rd_sel;
    logic [ADDR_W-1:0]   ar_rd_data;

    logic                mem_enable_read;
    logic                mem_enable_write;
    logic [ADDR_W-1:0]   mem_addr;
    logic [7:0]          mem_data_out;
    logic [7:0]          mem_data_in;

    logic                rsp_valid;
    logic [DATA_W-1:0]   rsp_rdata;

    modport master (
        output req_valid, req_store, req_mode, req_ar, req_post, req_wdata,
        output ar_wr_en, ar_wr_sel, ar_wr_data, ar_rd_sel,
        output mem_data_in,
        input  req_ready, ar_rd_data,
        input  mem_enable_read, mem_enable_write, mem_addr, mem_data_out,
        input  rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_store, req_mode, req_ar, req_post, req_wdata,
        input  ar_wr_en, ar_wr_sel, ar_wr_data, ar_rd_sel,
        input  mem_data_in,
        output req_ready, ar_rd_data,
        output mem_enable_read, mem_enable_write, mem_addr, mem_data_out,
        output rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/xmem_seq.sv
// XMEM load/store sequencer: byte-serial little-endian accesses with an address-register bank.
// Optional feature macro: XMEM_PREDEC_EN (req_post=11 performs pre-decrement when defined).
module xmem_seq #(
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned N_AR   = 2
) (
    input logic       clk,
    input logic       rst,
    xmem_seq_if.slave bus
);
    localparam int unsigned ArSelW = ($clog2(N_AR) > 1) ? $clog2(N_AR) : 1;
    localparam int unsigned NbMax  = DATA_W / 8;
    localparam int unsigned CntW   = ($clog2(NbMax) > 1) ? $clog2(NbMax) : 1;

    if ((DATA_W % 8) != 0 || DATA_W < 16) begin : g_bad_data_w
        $error("xmem_seq: DATA_W must be a multiple of 8 and at least 16");
    end
    if (N_AR < 2) begin : g_bad_n_ar
        $error("xmem_seq: N_AR must be at least 2");
    end

    typedef enum logic [1:0] {StIdle, StXfer, StResp} state_e;

    // Index of the final byte for a given access size.
    function automatic logic [CntW-1:0] last_idx(input logic [1:0] mode);
        case (mode)
            2'b10:   last_idx = CntW'(1);
            2'b11:   last_idx = CntW'(NbMax - 1);
            default: last_idx = '0;
        endcase
    endfunction

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ar_q [N_AR];
    logic                store_q;
    logic [1:0]          mode_q;
    logic [1:0]          post_q;
    logic [ArSelW-1:0]   sel_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [ADDR_W-1:0]   base_q;
    logic [CntW-1:0]     cnt_q;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]   rdata_q;

    logic [ADDR_W-1:0]   ar_req_val, ar_rd_val;
    logic [ADDR_W-1:0]   req_base;
    logic [ADDR_W-1:0]   cur_n;
    logic                xfer_last;
    logic [7:0]          wbyte, rbyte;
    logic                upd_en;
    logic [ADDR_W-1:0]   upd_val;
    logic                ar_upd;

    logic                accept;
    logic                req_ready, rsp_valid, mem_rd, mem_wr;
    logic [ADDR_W-1:0]   mem_addr;
    logic [7:0]          mem_dout;

    always_comb begin
        ar_req_val = '0;
        ar_rd_val  = '0;
        for (int i = 0; i < N_AR; i++) begin
            if (bus.req_ar == ArSelW'(i)) ar_req_val = ar_q[i];
            if (bus.ar_rd_sel == ArSelW'(i)) ar_rd_val = ar_q[i];
        end
    end

`ifdef XMEM_PREDEC_EN
    logic [ADDR_W-1:0] req_n;
    assign req_n    = ADDR_W'(last_idx(bus.req_mode)) + ADDR_W'(1);
    assign req_base = (bus.req_post == 2'b11) ? ar_req_val - req_n : ar_req_val;
`else
    assign req_base = ar_req_val;
`endif

    assign cur_n     = ADDR_W'(last_idx(mode_q)) + ADDR_W'(1);
    assign xfer_last = (cnt_q == last_idx(mode_q));

    // Nibble accesses carry only the low four bits in either direction.
    always_comb begin
        wbyte = 8'(wdata_q >> {cnt_q, 3'b000});
        if (mode_q == 2'b00) wbyte[7:4] = 4'h0;
        rbyte = bus.mem_data_in;
        if (mode_q == 2'b00) rbyte[7:4] = 4'h0;
        acc_d = acc_q | (DATA_W'(rbyte) << {cnt_q, 3'b000});
    end

    always_comb begin
        upd_en  = 1'b0;
        upd_val = base_q;
        case (post_q)
            2'b01: begin
                upd_en  = 1'b1;
                upd_val = base_q + cur_n;
            end
            2'b10: begin
                upd_en  = 1'b1;
                upd_val = base_q - cur_n;
            end
`ifdef XMEM_PREDEC_EN
            2'b11: upd_en = 1'b1;
`endif
            default: ;
        endcase
    end

    assign ar_upd = (state_q == StXfer) && xfer_last && upd_en;

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_dout  = '0;
        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (bus.req_valid) begin
                    accept  = 1'b1;
                    state_d = StXfer;
                end
            end
            StXfer: begin
                mem_rd   = ~store_q;
                mem_wr   = store_q;
                mem_addr = base_q + ADDR_W'(cnt_q);
                mem_dout = store_q ? wbyte : 8'h00;
                if (xfer_last) state_d = StResp;
            end
            StResp: begin
                rsp_valid = 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            store_q <= 1'b0;
            mode_q  <= 2'b00;
            post_q  <= 2'b00;
            sel_q   <= '0;
            wdata_q <= '0;
            base_q  <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                store_q <= bus.req_store;
                mode_q  <= bus.req_mode;
                post_q  <= bus.req_post;
                sel_q   <= bus.req_ar;
                wdata_q <= bus.req_wdata;
                base_q  <= req_base;
                cnt_q   <= '0;
                acc_q   <= '0;
            end else if (state_q == StXfer) begin
                cnt_q <= cnt_q + CntW'(1);
                if (!store_q) begin
                    acc_q <= acc_d;
                    if (xfer_last) rdata_q <= acc_d;
                end
            end
        end
    end

    // A direct write wins over the access update on the same register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_AR; i++) ar_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_AR; i++) begin
                if (bus.ar_wr_en && (bus.ar_wr_sel == ArSelW'(i))) begin
                    ar_q[i] <= bus.ar_wr_data;
                end else if (ar_upd && (sel_q == ArSelW'(i))) begin
                    ar_q[i] <= upd_val;
                end
            end
        end
    end

    assign bus.req_ready        = req_ready;
    assign bus.rsp_valid        = rsp_valid;
    assign bus.rsp_rdata        = rdata_q;
    assign bus.ar_rd_data       = ar_rd_val;
    assign bus.mem_enable_read  = mem_rd;
    assign bus.mem_enable_write = mem_wr;
    assign bus.mem_addr         = mem_addr;
    assign bus.mem_data_out     = mem_dout;
endmodule

// File: tb/tb_xmem_seq.sv
// Scoreboard bench for xmem_seq (DATA_W=32) against a byte-wide memory model.
module tb_xmem_seq;
    localparam int unsigned ADDR_W = 15;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned N_AR   = 2;
    localparam int unsigned MEM_SZ = 1 << ADDR_W;

    typedef struct {
        logic [DATA_W-1:0] rdata;
        int unsigned       cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    xmem_seq_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_AR(N_AR)) bus ();

    xmem_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_AR(N_AR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0]        mem [MEM_SZ];
    logic              mem_clr = 1'b1;
    logic              pl_en   = 1'b0;
    logic [ADDR_W-1:0] pl_addr = '0;
    logic [7:0]        pl_data = '0;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < MEM_SZ; i++) mem[i] <= 8'h00;
            mem_clr <= 1'b0;
        end else if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (bus.mem_enable_write) begin
            mem[bus.mem_addr] <= bus.mem_data_out;
        end
    end
    assign bus.mem_data_in = bus.mem_enable_read ? mem[bus.mem_addr] : 8'h00;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t              sbq[$];
    int                errors  = 0;
    int                checks  = 0;
    logic [DATA_W-1:0] last_rd = '0;
    int unsigned       acc1, acc2;

    function automatic int unsigned nbytes(input logic [1:0] mode);
        case (mode)
            2'b10:   nbytes = 2;
            2'b11:   nbytes = DATA_W / 8;
            default: nbytes = 1;
        endcase
    endfunction

    task automatic chk(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_ar(input int idx, input logic [ADDR_W-1:0] exp);
        bus.ar_rd_sel = 1'(idx);
        #1;
        chk($sformatf("ar%0d", idx), DATA_W'(bus.ar_rd_data), DATA_W'(exp));
    endtask

    task automatic chk_mem(input logic [ADDR_W-1:0] a, input logic [7:0] exp);
        chk($sformatf("mem[%0h]", a), DATA_W'(mem[a]), DATA_W'(exp));
    endtask

    task automatic ar_write(input int idx, input logic [ADDR_W-1:0] v);
        bus.ar_wr_en   = 1'b1;
        bus.ar_wr_sel  = 1'(idx);
        bus.ar_wr_data = v;
        @(negedge clk);
        bus.ar_wr_en = 1'b0;
    endtask

    task automatic poke(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Raises the request, waits for acceptance and queues the expected response.
    task automatic issue(input logic st, input logic [1:0] mode, input int ar,
                         input logic [1:0] post, input logic [DATA_W-1:0] wd,
                         input logic [DATA_W-1:0] ld_exp, output int unsigned acc);
        exp_t e;
        bus.req_store = st;
        bus.req_mode  = mode;
        bus.req_ar    = 1'(ar);
        bus.req_post  = post;
        bus.req_wdata = wd;
        bus.req_valid = 1'b1;
        acc = 0;
        for (int t = 0; t < 40 && !bus.req_ready; t++) @(negedge clk);
        if (!bus.req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: req_ready=0 after 40 cycles, required 1");
            return;
        end
        if (!st) last_rd = ld_exp;
        acc     = cyc + 1;
        e.rdata = last_rd;
        e.cyc   = acc + nbytes(mode);
        sbq.push_back(e);
        @(negedge clk);
    endtask

    task automatic wait_done();
        bus.req_valid = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (bus.req_ready && sbq.size() == 0) return;
        end
        checks++;
        errors++;
        $display("FAIL done_timeout: %0d responses outstanding, required 0", sbq.size());
    endtask

    task automatic op(input logic st, input logic [1:0] mode, input int ar,
                      input logic [1:0] post, input logic [DATA_W-1:0] wd,
                      input logic [DATA_W-1:0] ld_exp);
        int unsigned acc;
        issue(st, mode, ar, post, wd, ld_exp, acc);
        wait_done();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_store  = 1'b0;
        bus.req_mode   = 2'b00;
        bus.req_ar     = '0;
        bus.req_post   = 2'b00;
        bus.req_wdata  = '0;
        bus.ar_wr_en   = 1'b0;
        bus.ar_wr_sel  = '0;
        bus.ar_wr_data = '0;
        bus.ar_rd_sel  = '0;

        fork
            forever begin
                exp_t e;
                @(negedge clk);
                if (rst && bus.rsp_valid) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rsp_unexpected: rsp_valid=1, required 0");
                    end else begin
                        e = sbq.pop_front();
                        chk("rsp_rdata", bus.rsp_rdata, e.rdata);
                        chk("rsp_cycle", DATA_W'(cyc), DATA_W'(e.cyc));
                    end
                end
            end
        join_none

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req_ready", DATA_W'(bus.req_ready), 1);
        chk("rst_rsp_valid", DATA_W'(bus.rsp_valid), 0);
        chk("rst_strobes", DATA_W'({bus.mem_enable_read, bus.mem_enable_write}), 0);
        chk("rst_mem_addr", DATA_W'(bus.mem_addr), 0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 0);
        chk_ar(0, 15'h0000);
        chk_ar(1, 15'h0000);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Nibble: upper wdata bits must be dropped on the bus
        ar_write(0, 15'h0080);
        op(1'b1, 2'b00, 0, 2'b01, 32'h0000_00A5, '0);
        op(1'b1, 2'b00, 0, 2'b00, 32'h0000_00C3, '0);
        op(1'b0, 2'b00, 0, 2'b00, '0, 32'h0000_0003);
        chk_mem(15'h0080, 8'h05);
        chk_mem(15'h0081, 8'h03);
        chk_ar(0, 15'h0081);

        // Byte
        poke(15'h0082, 8'hEE);
        op(1'b1, 2'b01, 0, 2'b01, 32'h0000_005B, '0);
        op(1'b1, 2'b01, 0, 2'b00, 32'h0000_0000, '0);
        chk_mem(15'h0081, 8'h5B);
        chk_mem(15'h0082, 8'h00);
        op(1'b0, 2'b01, 0, 2'b01, '0, 32'h0000_0000);
        op(1'b0, 2'b01, 0, 2'b10, '0, 32'h0000_0000);
        chk_ar(0, 15'h0082);

        // 16-bit on AR1
        ar_write(1, 15'h0090);
        op(1'b1, 2'b10, 1, 2'b01, 32'hDEAD_1234, '0);
        chk_mem(15'h0090, 8'h34);
        chk_mem(15'h0091, 8'h12);
        chk_mem(15'h0092, 8'h00);
        chk_ar(1, 15'h0092);
        op(1'b0, 2'b10, 1, 2'b10, '0, 32'h0000_0000);
        chk_ar(1, 15'h0090);
        op(1'b0, 2'b10, 1, 2'b00, '0, 32'h0000_1234);
        chk_ar(1, 15'h0090);

        // Full width across the top of the address space
        ar_write(1, 15'h7FFE);
        op(1'b1, 2'b11, 1, 2'b01, 32'hCAFE_BABE, '0);
        chk_mem(15'h7FFE, 8'hBE);
        chk_mem(15'h7FFF, 8'hBA);
        chk_mem(15'h0000, 8'hFE);
        chk_mem(15'h0001, 8'hCA);
        chk_ar(1, 15'h0002);
`ifdef XMEM_PREDEC_EN
        op(1'b0, 2'b11, 1, 2'b11, '0, 32'hCAFE_BABE);
        chk_ar(1, 15'h7FFE);
`else
        op(1'b0, 2'b11, 1, 2'b11, '0, 32'h0000_0000);
        chk_ar(1, 15'h0002);
`endif

        // Post-dec wrapping below zero
        ar_write(0, 15'h0001);
        op(1'b0, 2'b10, 0, 2'b10, '0, 32'h0000_00CA);
        chk_ar(0, 15'h7FFF);

        // Direct write colliding with the same register's update
        issue(1'b1, 2'b01, 0, 2'b01, 32'h0000_0077, '0, acc1);
        ar_write(0, 15'h0100);
        wait_done();
        chk_ar(0, 15'h0100);
        chk_mem(15'h7FFF, 8'h77);

        // Direct write to a different register alongside the update
        issue(1'b1, 2'b01, 0, 2'b01, 32'h0000_0042, '0, acc1);
        ar_write(1, 15'h0333);
        wait_done();
        chk_ar(0, 15'h0101);
        chk_ar(1, 15'h0333);
        chk_mem(15'h0100, 8'h42);

        // Request held during XFER is taken only once req_ready returns
        poke(15'h0101, 8'h9C);
        poke(15'h0333, 8'h11);
        poke(15'h0334, 8'h22);
        issue(1'b0, 2'b01, 0, 2'b00, '0, 32'h0000_009C, acc1);
        issue(1'b0, 2'b10, 1, 2'b00, '0, 32'h0000_2211, acc2);
        chk("stall_accept_cycle", DATA_W'(acc2), DATA_W'(acc1 + 3));
        wait_done();

        // Reset during byte 1 of a 16-bit store
        ar_write(0, 15'h0200);
        issue(1'b1, 2'b10, 0, 2'b01, 32'h0000_A1B2, '0, acc1);
        bus.req_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        sbq.delete();
        last_rd = '0;
        chk("abort_wr_strobe", DATA_W'(bus.mem_enable_write), 0);
        chk("abort_req_ready", DATA_W'(bus.req_ready), 1);
        chk("abort_rsp_rdata", bus.rsp_rdata, 0);
        chk_ar(0, 15'h0000);
        chk_ar(1, 15'h0000);
        @(negedge clk);
        @(negedge clk);
        chk_mem(15'h0200, 8'hB2);
        chk_mem(15'h0201, 8'h00);
        rst = 1'b1;
        @(negedge clk);

        // Operates normally after the abort
        op(1'b0, 2'b01, 0, 2'b00, '0, 32'h0000_00FE);
        chk_ar(0, 15'h0000);

        repeat (3) @(negedge clk);
        chk("sb_empty", DATA_W'(sbq.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
